// File: rtl/npu_act_wr_pkg.sv
// Shared types and constants for the activation write lane.
// Contents:
//   ACC_W_DEFAULT   default accumulator width
//   ACT_ADDR_W      activation memory address width
//   U8_MAX, S8_MAX, S8_MIN   clamp limits for the 8-bit result
//   SAT_CNT_W       width of the saturation counter
//   act_wr_entry_t  one pending write {addr, data}
//   sat_inc()       increment that sticks at all-ones

`ifndef LOG2_ACT_ADDR_WIDTH
`define LOG2_ACT_ADDR_WIDTH 12
`endif

package npu_act_wr_pkg;

   localparam int unsigned ACC_W_DEFAULT = 24;
   localparam int unsigned ACT_ADDR_W    = `LOG2_ACT_ADDR_WIDTH;

   localparam int U8_MAX = 255;
   localparam int S8_MAX = 127;
   localparam int S8_MIN = -128;

   localparam int unsigned SAT_CNT_W = 16;

   typedef struct packed {
      logic [ACT_ADDR_W-1:0] addr;
      logic [7:0]            data;
   } act_wr_entry_t;

   function automatic logic [SAT_CNT_W-1:0] sat_inc(input logic [SAT_CNT_W-1:0] cnt);
      return (&cnt) ? cnt : cnt + SAT_CNT_W'(1);
   endfunction

endpackage

// File: rtl/npu_act_wr_fifo.sv
// Synchronous FIFO of pending activation writes.
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   push, wdata   enqueue an entry (ignored when full without a pop)
//   pop           dequeue the head (ignored when empty)
//   rdata         head entry, valid while ~empty
//   full, empty   occupancy flags
//   count         number of stored entries, 0..DEPTH
// Push and pop in the same cycle are allowed at any occupancy, including full.

module npu_act_wr_fifo
   import npu_act_wr_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     push,
   input  act_wr_entry_t            wdata,
   input  logic                     pop,
   output act_wr_entry_t            rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);

   act_wr_entry_t       mem_q [DEPTH];
   logic [PW-1:0]       wptr_q;
   logic [PW-1:0]       rptr_q;
   logic [PW:0]         count_q;
   logic [PW:0]         count_d;
   logic                push_en;
   logic                pop_en;

   assign full  = (count_q == (PW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign rdata = mem_q[rptr_q];

   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign pop_en  = pop & ~empty;
   assign push_en = push & (~full | pop_en);

   always_comb begin
      count_d = count_q;
      unique case ({push_en, pop_en})
         2'b10:   count_d = count_q + (PW+1)'(1);
         2'b01:   count_d = count_q - (PW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         count_q <= count_d;
         if (push_en) begin
            mem_q[wptr_q] <= wdata;
            wptr_q        <= wptr_q + PW'(1);
         end
         if (pop_en) begin
            rptr_q <= rptr_q + PW'(1);
         end
      end
   end

endmodule

// File: rtl/npu_act_wr_lane.sv
// Per-lane activation output stage: requantises accumulator results to 8 bits,
// tags each with an activation-memory address and queues it for the write arbiter.
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   layer_start                 reload address counter from cfg_base_addr, clear sat_cnt
//   cfg_base_addr/addr_stride   per-layer address generation
//   cfg_shift, cfg_relu_en      requantisation controls (static during a layer)
//   acc_valid/acc_data/acc_ready  accumulator result handshake
//   hw_mem_wr, _addr, _data     write request, held until hw_mem_wr_ack_p
//   hw_mem_wr_ack_p             single-cycle acknowledge, pops the head entry
//   lane_idle                   nothing in the pipeline or FIFO
//   sat_cnt                     saturating count of clamped results
// Pipeline: accept -> S1 (round+shift) -> S2 (clamp) -> FIFO.

module npu_act_wr_lane
   import npu_act_wr_pkg::*;
#(
   parameter int unsigned ACC_W      = ACC_W_DEFAULT,
   parameter int unsigned ADDR_W     = ACT_ADDR_W,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  layer_start,
   input  logic [ADDR_W-1:0]     cfg_base_addr,
   input  logic [ADDR_W-1:0]     cfg_addr_stride,
   input  logic [4:0]            cfg_shift,
   input  logic                  cfg_relu_en,
   input  logic                  acc_valid,
   input  logic [ACC_W-1:0]      acc_data,
   output logic                  acc_ready,
   output logic                  hw_mem_wr,
   output logic [ADDR_W-1:0]     hw_mem_wr_addr,
   output logic [7:0]            hw_mem_wr_data,
   input  logic                  hw_mem_wr_ack_p,
   output logic                  lane_idle,
   output logic [SAT_CNT_W-1:0]  sat_cnt
);

   // One extra bit keeps acc + rounding bias from overflowing.
   localparam int unsigned VW = ACC_W + 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned OW = $clog2(FIFO_DEPTH + 3);

   localparam logic signed [VW-1:0] U8_MAX_V = VW'(U8_MAX);
   localparam logic signed [VW-1:0] S8_MAX_V = VW'(S8_MAX);
   localparam logic signed [VW-1:0] S8_MIN_V = VW'(S8_MIN);

   logic [ADDR_W-1:0]      addr_q;
   logic [ADDR_W-1:0]      addr_d;
   logic [ADDR_W-1:0]      beat_addr;
   logic                   accept;

   logic signed [VW-1:0]   acc_ext;
   logic signed [VW-1:0]   rnd_bias;
   logic signed [VW-1:0]   rounded;
   logic signed [VW-1:0]   shifted;

   logic                   s1_valid_q;
   logic signed [VW-1:0]   s1_val_q;
   logic [ADDR_W-1:0]      s1_addr_q;

   logic [7:0]             clamp_data;
   logic                   clamp_sat;

   logic                   s2_valid_q;
   act_wr_entry_t          s2_entry_q;

   logic [SAT_CNT_W-1:0]   sat_cnt_q;

   act_wr_entry_t          fifo_head;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [CW-1:0]          fifo_count;
   logic [OW-1:0]          occupancy;

   // Credit covers every in-flight beat, so S2 always finds room in the FIFO.
   assign occupancy = OW'(s1_valid_q) + OW'(s2_valid_q) + OW'(fifo_count);
   assign acc_ready = (occupancy < OW'(FIFO_DEPTH));
   assign accept    = acc_valid & acc_ready;

   // A beat accepted together with layer_start belongs to the new layer.
   assign beat_addr = layer_start ? cfg_base_addr : addr_q;

   always_comb begin
      addr_d = addr_q;
      if (accept) begin
         addr_d = beat_addr + cfg_addr_stride;
      end else if (layer_start) begin
         addr_d = cfg_base_addr;
      end
   end

   // Round half up, then arithmetic shift.
   always_comb begin
      acc_ext  = $signed({acc_data[ACC_W-1], acc_data});
      rnd_bias = '0;
      if (cfg_shift != 5'd0) begin
         rnd_bias = VW'(1) << (cfg_shift - 5'd1);
      end
      rounded = acc_ext + rnd_bias;
      shifted = rounded >>> cfg_shift;
   end

   // ReLU zeroing of negatives is intentional, not a clamp, so it is not counted.
   always_comb begin
      clamp_data = s1_val_q[7:0];
      clamp_sat  = 1'b0;
      if (cfg_relu_en) begin
         if (s1_val_q[VW-1]) begin
            clamp_data = 8'h00;
         end else if (s1_val_q > U8_MAX_V) begin
            clamp_data = 8'hFF;
            clamp_sat  = 1'b1;
         end
      end else begin
         if (s1_val_q > S8_MAX_V) begin
            clamp_data = 8'h7F;
            clamp_sat  = 1'b1;
         end else if (s1_val_q < S8_MIN_V) begin
            clamp_data = 8'h80;
            clamp_sat  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         addr_q     <= '0;
         s1_valid_q <= 1'b0;
         s1_val_q   <= '0;
         s1_addr_q  <= '0;
         s2_valid_q <= 1'b0;
         s2_entry_q <= '0;
         sat_cnt_q  <= '0;
      end else begin
         addr_q     <= addr_d;
         s1_valid_q <= accept;
         if (accept) begin
            s1_val_q  <= shifted;
            s1_addr_q <= beat_addr;
         end
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_entry_q.addr <= s1_addr_q;
            s2_entry_q.data <= clamp_data;
         end
         // The layer boundary clear takes priority over a late clamp.
         if (layer_start) begin
            sat_cnt_q <= '0;
         end else if (s1_valid_q && clamp_sat) begin
            sat_cnt_q <= sat_inc(sat_cnt_q);
         end
      end
   end

   npu_act_wr_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (s2_valid_q),
      .wdata  (s2_entry_q),
      .pop    (hw_mem_wr_ack_p),
      .rdata  (fifo_head),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .count  (fifo_count)
   );

   no_fifo_overflow: assert property (@(posedge clk) disable iff (!resetn)
      !(s2_valid_q && fifo_full && !(hw_mem_wr_ack_p && !fifo_empty)));

   assign hw_mem_wr      = ~fifo_empty;
   assign hw_mem_wr_addr = fifo_head.addr;
   assign hw_mem_wr_data = fifo_head.data;
   assign lane_idle      = ~s1_valid_q & ~s2_valid_q & fifo_empty;
   assign sat_cnt        = sat_cnt_q;

endmodule

// File: tb/tb_npu_act_wr_lane.sv
module tb_npu_act_wr_lane;
   import npu_act_wr_pkg::*;

   localparam int unsigned AW = ACT_ADDR_W;
   localparam int AMASK = (1 << AW) - 1;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          layer_start = 1'b0;
   logic [AW-1:0] cfg_base_addr = '0;
   logic [AW-1:0] cfg_addr_stride = '0;
   logic [4:0]    cfg_shift = '0;
   logic          cfg_relu_en = 1'b0;
   logic          acc_valid = 1'b0;
   logic [23:0]   acc_data = '0;
   logic          acc_ready;
   logic          hw_mem_wr;
   logic [AW-1:0] hw_mem_wr_addr;
   logic [7:0]    hw_mem_wr_data;
   logic          hw_mem_wr_ack_p = 1'b0;
   logic          lane_idle;
   logic [15:0]   sat_cnt;

   always #5 clk = ~clk;

   npu_act_wr_lane dut (
      .clk             (clk),
      .resetn          (resetn),
      .layer_start     (layer_start),
      .cfg_base_addr   (cfg_base_addr),
      .cfg_addr_stride (cfg_addr_stride),
      .cfg_shift       (cfg_shift),
      .cfg_relu_en     (cfg_relu_en),
      .acc_valid       (acc_valid),
      .acc_data        (acc_data),
      .acc_ready       (acc_ready),
      .hw_mem_wr       (hw_mem_wr),
      .hw_mem_wr_addr  (hw_mem_wr_addr),
      .hw_mem_wr_data  (hw_mem_wr_data),
      .hw_mem_wr_ack_p (hw_mem_wr_ack_p),
      .lane_idle       (lane_idle),
      .sat_cnt         (sat_cnt)
   );

   // Reference model: ordered list of writes the lane owes the arbiter.
   typedef struct {
      logic [AW-1:0] addr;
      logic [7:0]    data;
   } exp_t;

   exp_t exp_q[$];
   int   mdl_addr, mdl_base, mdl_stride, mdl_shift, mdl_sat;
   bit   mdl_relu;
   int   total = 0;
   int   bad = 0;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic void requant(input int acc, input int shift, input bit relu,
                                   output int data, output bit sat);
      int v;
      v   = acc;
      sat = 1'b0;
      if (shift > 0) v = (v + (1 << (shift - 1))) >>> shift;
      if (relu) begin
         if (v < 0) v = 0;
         else if (v > 255) begin v = 255; sat = 1'b1; end
      end else begin
         if (v > 127) begin v = 127; sat = 1'b1; end
         else if (v < -128) begin v = -128; sat = 1'b1; end
      end
      data = v & 255;
   endfunction

   task automatic set_cfg(input int base, input int stride, input int shift, input bit relu);
      cfg_base_addr   = AW'(base);
      cfg_addr_stride = AW'(stride);
      cfg_shift       = 5'(shift);
      cfg_relu_en     = relu;
      mdl_base = base & AMASK;
      mdl_stride = stride & AMASK;
      mdl_shift = shift;
      mdl_relu = relu;
   endtask

   task automatic do_layer_start();
      layer_start = 1'b1;
      cyc();
      layer_start = 1'b0;
      mdl_addr = mdl_base;
      mdl_sat = 0;
   endtask

   // Model side of one accepted beat.
   task automatic accept_model(input logic [23:0] d, input bit ls);
      int   a, dv;
      bit   s;
      exp_t e;
      a = {{8{d[23]}}, d};
      if (ls) begin
         mdl_addr = mdl_base;
         mdl_sat = 0;
      end
      requant(a, mdl_shift, mdl_relu, dv, s);
      e.addr = AW'(mdl_addr);
      e.data = 8'(dv);
      exp_q.push_back(e);
      if (s && mdl_sat < 65535) mdl_sat++;
      mdl_addr = (mdl_addr + mdl_stride) & AMASK;
   endtask

   task automatic send(input logic [23:0] d, input bit ls, output bit ok);
      ok = 1'b0;
      acc_valid = 1'b1;
      acc_data = d;
      layer_start = ls;
      for (int i = 0; i < 200 && !ok; i++) begin
         if (acc_ready) begin
            accept_model(d, ls);
            ok = 1'b1;
         end else if (ls) begin
            mdl_addr = mdl_base;
            mdl_sat = 0;
         end
         cyc();
      end
      acc_valid = 1'b0;
      layer_start = 1'b0;
   endtask

   // Waits (bounded) for a request, captures head, acknowledges it.
   task automatic ack_head(output logic [AW-1:0] a, output logic [7:0] d, output bit seen);
      seen = 1'b0;
      a = '0;
      d = '0;
      for (int i = 0; i < 100 && !seen; i++) begin
         if (hw_mem_wr) seen = 1'b1;
         else cyc();
      end
      if (seen) begin
         a = hw_mem_wr_addr;
         d = hw_mem_wr_data;
         hw_mem_wr_ack_p = 1'b1;
         cyc();
         hw_mem_wr_ack_p = 1'b0;
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      #12;
      total += 6;
      if (acc_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", acc_ready); end
      if (hw_mem_wr !== 1'b0) begin bad++; $display("FAIL rst_wr: got %b want 0", hw_mem_wr); end
      if (hw_mem_wr_addr !== '0) begin bad++; $display("FAIL rst_addr: got %h want 0", hw_mem_wr_addr); end
      if (hw_mem_wr_data !== 8'h00) begin bad++; $display("FAIL rst_data: got %h want 0", hw_mem_wr_data); end
      if (lane_idle !== 1'b1) begin bad++; $display("FAIL rst_idle: got %b want 1", lane_idle); end
      if (sat_cnt !== 16'h0) begin bad++; $display("FAIL rst_sat: got %h want 0", sat_cnt); end
      @(negedge clk);
      resetn = 1'b1;
      cyc();
      mdl_addr = 0;
      mdl_sat = 0;
   endtask

   task automatic test_basic();
      logic [AW-1:0] a;
      logic [7:0]    d;
      bit            ok, seen;
      exp_t          e;
      set_cfg('h010, 1, 4, 1'b1);
      do_layer_start();
      send(24'h000123, 1'b0, ok);
      cyc();
      total += 2;
      if (hw_mem_wr !== 1'b0) begin bad++; $display("FAIL basic_lat1: got wr=%b want 0", hw_mem_wr); end
      cyc();
      if (hw_mem_wr !== 1'b1) begin bad++; $display("FAIL basic_lat2: got wr=%b want 1", hw_mem_wr); end
      ack_head(a, d, seen);
      e = exp_q.pop_front();
      total += 3;
      if (!ok || !seen || a !== e.addr || d !== e.data)
         begin bad++; $display("FAIL basic_wr: got %h/%h want %h/%h", a, d, e.addr, e.data); end
      if (e.addr !== AW'('h010) || e.data !== 8'h12)
         begin bad++; $display("FAIL basic_model: got %h/%h want 010/12", e.addr, e.data); end
      if (hw_mem_wr !== 1'b0 || lane_idle !== 1'b1)
         begin bad++; $display("FAIL basic_after_ack: got wr=%b idle=%b want 0/1", hw_mem_wr, lane_idle); end
   endtask

   task automatic test_rounding();
      logic [AW-1:0] a;
      logic [7:0]    d;
      bit            ok, seen;
      exp_t          e;
      logic [23:0]   vals [3];
      vals[0] = 24'd7;
      vals[1] = -24'sd7;
      vals[2] = 24'd6;
      set_cfg('h010, 1, 2, 1'b0);
      for (int i = 0; i < 3; i++) send(vals[i], 1'b0, ok);
      for (int i = 0; i < 3; i++) begin
         ack_head(a, d, seen);
         e = exp_q.pop_front();
         total++;
         if (!seen || a !== e.addr || d !== e.data)
            begin bad++; $display("FAIL round_%0d: got %h/%h want %h/%h", i, a, d, e.addr, e.data); end
      end
      total++;
      if (sat_cnt !== 16'(mdl_sat) || mdl_sat != 0)
         begin bad++; $display("FAIL round_sat: got %0d want 0", sat_cnt); end
   endtask

   task automatic test_saturation();
      logic [AW-1:0] a;
      logic [7:0]    d;
      bit            ok, seen;
      exp_t          e;
      logic [23:0]   vals [4];
      vals[0] = 24'd300;
      vals[1] = -24'sd5;
      vals[2] = 24'd200;
      vals[3] = -24'sd200;
      set_cfg('h080, 3, 0, 1'b1);
      do_layer_start();
      for (int i = 0; i < 4; i++) begin
         if (i == 2) set_cfg('h080, 3, 0, 1'b0);
         send(vals[i], 1'b0, ok);
         ack_head(a, d, seen);
         e = exp_q.pop_front();
         total++;
         if (!seen || a !== e.addr || d !== e.data)
            begin bad++; $display("FAIL sat_%0d: got %h/%h want %h/%h", i, a, d, e.addr, e.data); end
      end
      total++;
      if (sat_cnt !== 16'(mdl_sat) || sat_cnt !== 16'd3)
         begin bad++; $display("FAIL sat_cnt: got %0d want 3", sat_cnt); end
   endtask

   task automatic test_back_to_back();
      logic [23:0]   bp [6];
      logic [AW-1:0] a;
      logic [7:0]    d;
      exp_t          e;
      int            sent;
      bit            hi_ok, seen;
      for (int i = 0; i < 6; i++) bp[i] = 24'($urandom_range(0, 100));
      set_cfg('h100, 1, 0, 1'b0);
      do_layer_start();
      sent = 0;
      for (int c = 0; c < 12; c++) begin
         acc_valid = (sent < 6);
         acc_data = bp[sent < 6 ? sent : 5];
         if (acc_valid && acc_ready) begin accept_model(acc_data, 1'b0); sent++; end
         cyc();
      end
      total += 2;
      if (sent != 4) begin bad++; $display("FAIL bp_accepted: got %0d want 4", sent); end
      if (acc_ready !== 1'b0) begin bad++; $display("FAIL bp_ready: got %b want 0", acc_ready); end
      for (int k = 0; k < 6; k++) begin
         hi_ok = 1'b1;
         for (int w = 0; w < 32; w++) begin
            acc_valid = (sent < 6);
            acc_data = bp[sent < 6 ? sent : 5];
            seen = 1'b0;
            if (w == 31) begin
               seen = hw_mem_wr;
               a = hw_mem_wr_addr;
               d = hw_mem_wr_data;
               hw_mem_wr_ack_p = 1'b1;
            end
            if (!hw_mem_wr) hi_ok = 1'b0;
            if (acc_valid && acc_ready) begin accept_model(acc_data, 1'b0); sent++; end
            cyc();
            hw_mem_wr_ack_p = 1'b0;
            if (w == 31) begin
               e = exp_q.pop_front();
               total += 2;
               if (!seen || a !== e.addr || d !== e.data)
                  begin bad++; $display("FAIL bp_wr_%0d: got %h/%h want %h/%h", k, a, d, e.addr, e.data); end
               if (k < 4 && e.addr !== AW'('h100 + k))
                  begin bad++; $display("FAIL bp_order_%0d: got %h want %h", k, e.addr, 'h100 + k); end
            end
         end
         total++;
         if (!hi_ok) begin bad++; $display("FAIL bp_hold_%0d: got wr dropped want held", k); end
      end
      acc_valid = 1'b0;
      total++;
      if (hw_mem_wr !== 1'b0 || sent != 6)
         begin bad++; $display("FAIL bp_end: got wr=%b sent=%0d want 0/6", hw_mem_wr, sent); end
   endtask

   task automatic test_wrap_layer();
      logic [AW-1:0] a;
      logic [7:0]    d;
      bit            ok, seen;
      exp_t          e;
      set_cfg(AMASK, 1, 0, 1'b0);
      do_layer_start();
      send(24'd11, 1'b0, ok);
      send(24'd22, 1'b0, ok);
      cyc(); cyc(); cyc();
      set_cfg('h040, 1, 0, 1'b0);
      send(24'd33, 1'b1, ok);
      send(24'd44, 1'b0, ok);
      for (int i = 0; i < 4; i++) begin
         ack_head(a, d, seen);
         e = exp_q.pop_front();
         total++;
         if (!seen || a !== e.addr || d !== e.data)
            begin bad++; $display("FAIL wrap_%0d: got %h/%h want %h/%h", i, a, d, e.addr, e.data); end
      end
   endtask

   task automatic test_random();
      logic [AW-1:0] a;
      logic [7:0]    d;
      exp_t          e;
      int            sent, errs, cnt;
      logic [23:0]   v;
      for (int b = 0; b < 3; b++) begin
         set_cfg($urandom, $urandom_range(1, 9), $urandom_range(0, 23), 1'($urandom));
         do_layer_start();
         sent = 0;
         errs = 0;
         cnt = 0;
         while ((sent < 15 || exp_q.size() != 0) && cnt < 2000) begin
            acc_valid = (sent < 15) && ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) != 0) v = 24'($urandom);
            else v = 24'($signed($urandom_range(0, 1200)) - 600);
            acc_data = v;
            hw_mem_wr_ack_p = 1'($urandom);
            if (hw_mem_wr_ack_p && hw_mem_wr) begin
               if (exp_q.size() == 0) begin
                  errs++;
                  $display("FAIL rnd_extra: got %h/%h want none", hw_mem_wr_addr, hw_mem_wr_data);
               end else begin
                  e = exp_q.pop_front();
                  a = hw_mem_wr_addr;
                  d = hw_mem_wr_data;
                  if (a !== e.addr || d !== e.data) begin
                     errs++;
                     $display("FAIL rnd_wr: got %h/%h want %h/%h", a, d, e.addr, e.data);
                  end
               end
            end
            if (acc_valid && acc_ready) begin accept_model(acc_data, 1'b0); sent++; end
            cyc();
            cnt++;
         end
         acc_valid = 1'b0;
         hw_mem_wr_ack_p = 1'b0;
         cyc();
         total += 3;
         if (errs != 0) bad++;
         if (cnt >= 2000 || lane_idle !== 1'b1)
            begin bad++; $display("FAIL rnd_drain: got left=%0d idle=%b want 0/1", exp_q.size(), lane_idle); end
         if (sat_cnt !== 16'(mdl_sat))
            begin bad++; $display("FAIL rnd_sat: got %0d want %0d", sat_cnt, mdl_sat); end
      end
   endtask

   task automatic test_reset_mid();
      bit ok, wrote;
      set_cfg('h200, 2, 0, 1'b0);
      do_layer_start();
      send(24'd1000, 1'b0, ok);
      send(24'd5, 1'b0, ok);
      send(-24'sd3, 1'b0, ok);
      cyc(); cyc(); cyc();
      total++;
      if (sat_cnt !== 16'(mdl_sat) || !hw_mem_wr)
         begin bad++; $display("FAIL mid_pre: got sat=%0d wr=%b want %0d/1", sat_cnt, hw_mem_wr, mdl_sat); end
      @(negedge clk);
      resetn = 1'b0;
      #2;
      total += 4;
      if (hw_mem_wr !== 1'b0) begin bad++; $display("FAIL mid_wr: got %b want 0", hw_mem_wr); end
      if (lane_idle !== 1'b1) begin bad++; $display("FAIL mid_idle: got %b want 1", lane_idle); end
      if (acc_ready !== 1'b1) begin bad++; $display("FAIL mid_ready: got %b want 1", acc_ready); end
      if (sat_cnt !== 16'h0) begin bad++; $display("FAIL mid_sat: got %0d want 0", sat_cnt); end
      @(negedge clk);
      resetn = 1'b1;
      exp_q.delete();
      mdl_addr = 0;
      mdl_sat = 0;
      wrote = 1'b0;
      hw_mem_wr_ack_p = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (hw_mem_wr || !lane_idle) wrote = 1'b1;
      end
      hw_mem_wr_ack_p = 1'b0;
      total++;
      if (wrote) begin bad++; $display("FAIL mid_post: got write after reset want none"); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_rounding();
      test_saturation();
      test_back_to_back();
      test_wrap_layer();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/npu_act_wr_lane.md
Name: npu_act_wr_lane

Overview:
- Per-lane output stage feeding the activation-memory write arbiter; 32 instances, one per arbiter request slot.
- Takes signed accumulator results from one MAC lane and requantises each one (round, shift, optional ReLU, saturate to 8 bits).
- Assigns each result an activation-memory address and holds a write request, with address and data, until the arbiter acknowledges it.
- A small FIFO absorbs arbiter service latency of up to 32 cycles per write.

Parameters:
- ACC_W, 24, accumulator width (signed).
- ADDR_W, `LOG2_ACT_ADDR_WIDTH, activation memory address width.
- FIFO_DEPTH, 4, pending-write entries (power of 2, >=2).

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, asynchronous, active-low.
- layer_start  in  1  pulse: reload address counter, clear sat_cnt.
- cfg_base_addr  in  ADDR_W  first address of this lane for the layer.
- cfg_addr_stride  in  ADDR_W  address increment per accepted result.
- cfg_shift  in  5  right-shift amount, 0..23.
- cfg_relu_en  in  1  1: clamp to [0,255]; 0: clamp to signed [-128,127].
- acc_valid  in  1  accumulator result valid.
- acc_data  in  ACC_W  signed accumulator result.
- acc_ready  out  1  lane can accept a result this cycle.
- hw_mem_wr  out  1  write request to the arbiter; held until acked.
- hw_mem_wr_addr  out  ADDR_W  head-entry address.
- hw_mem_wr_data  out  8  head-entry data.
- hw_mem_wr_ack_p  in  1  one-cycle acknowledge from the arbiter.
- lane_idle  out  1  pipeline and FIFO both empty.
- sat_cnt  out  16  saturating count of clamped results.

Behaviour:
- Reset values: acc_ready=1, hw_mem_wr=0, hw_mem_wr_addr=0, hw_mem_wr_data=0, lane_idle=1, sat_cnt=0. The address counter resets to 0.
- Accept: a beat is accepted when acc_valid & acc_ready.
  - The beat takes the current address counter value.
  - The counter then advances by cfg_addr_stride, wrapping mod 2^ADDR_W.
- layer_start:
  - Sets the address counter to cfg_base_addr and clears sat_cnt.
  - If a beat is accepted in the same cycle, that beat gets cfg_base_addr and the counter becomes cfg_base_addr+cfg_addr_stride.
  - In-flight entries keep the addresses they were already given.
- Pipeline S1 (registered at accept): add rounding bias 2^(cfg_shift-1) when cfg_shift>0, then arithmetic right shift by cfg_shift. Use ACC_W+1 bits so there is no overflow.
- Pipeline S2 (registered):
  - cfg_relu_en=1: negative -> 0; >255 -> 255.
  - cfg_relu_en=0: >127 -> 127; <-128 -> -128 (two's complement).
  - Any clamp increments sat_cnt, which sticks at 0xFFFF. ReLU zeroing of a negative value is not counted.
  - The result is pushed into the FIFO.
- Latency: a beat accepted at edge N is in the FIFO at edge N+2; hw_mem_wr can be high from cycle N+2.
- Credit: occupancy = S1 valid + S2 valid + FIFO count. acc_ready = (occupancy < FIFO_DEPTH) and is registered/derived so an accepted beat never overflows the FIFO. With FIFO_DEPTH in flight, acc_ready=0.
- Request outputs: hw_mem_wr = FIFO not empty. hw_mem_wr_addr and hw_mem_wr_data are driven directly from the FIFO head and are stable while hw_mem_wr=1.
- Ack:
  - hw_mem_wr_ack_p is combinational in the arbiter and is high in the same cycle the arbiter samples addr/data. The FIFO pops on that edge.
  - If another entry remains, hw_mem_wr stays high with the new head; the next ack comes on the arbiter's next sweep.
  - An ack while hw_mem_wr=0 is ignored.
- Simultaneous push and pop: allowed at any occupancy, including full with a pop; count is unchanged.
- lane_idle = ~S1 valid & ~S2 valid & FIFO empty.
- Config inputs are sampled at use (cfg_shift/cfg_relu_en at S1/S2). They are static during a layer.
- Reset mid-operation: all pending entries are discarded and outputs return to reset values.

Decomposition:
- Package npu_act_wr_pkg:
  - ACC_W default.
  - Entry struct {addr[ADDR_W], data[8]}.
  - Clamp constants: U8_MAX=255, S8_MAX=127, S8_MIN=-128.
  - SAT_CNT_W=16.
- Sub-module npu_act_wr_fifo:
  - Synchronous FIFO, parameter DEPTH, entry type from the package.
  - push/pop/full/empty/count; same-cycle push and pop allowed.

Test Plan:
- Basic path: base=0x010, stride=1, shift=4, relu=1; acc=0x000123 (291) -> data 0x12 at 0x010; ack the first time hw_mem_wr is seen high -> hw_mem_wr low the next cycle.
- Rounding and negative: shift=2, relu=0; acc=7 -> 2; acc=-7 -> -2 (0xFE); acc=6 -> 2 (6+2=8, >>2=2); sat_cnt stays 0.
- Saturation: relu=1, shift=0; acc=300 -> 255, acc=-5 -> 0; relu=0: acc=200 -> 127 (0x7F), acc=-200 -> -128 (0x80); sat_cnt=3 (the -5 ReLU zeroing is not counted).
- Back-pressure: stream 6 beats with ack withheld -> acc_ready=0 after 4 accepted. Then ack every 32 cycles -> 4 writes at addresses base..base+3 in order; hw_mem_wr stays high between acks; beats 5 and 6 follow.
- Wrap and layer_start: base=2^ADDR_W-1, stride=1 -> second address 0. layer_start with a concurrent accept and base=0x040 -> that beat at 0x040, the next at 0x041; pending older entries keep their old addresses.
- Reset mid-operation: 3 entries pending, assert resetn=0 -> hw_mem_wr=0, lane_idle=1, acc_ready=1, sat_cnt=0, no write issued after release.
